// File: rtl/stage_sequencer.sv
// stage_sequencer: stage-code generator, program-memory loader and run control.
// Loads words from a host stream, then cycles FETCH/DECODE/EXECUTE under halt/step/resume/reload.
module stage_sequencer #(
    parameter int ADDR_W = 8,
    parameter int IW     = 12,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ld_valid,
    input  logic [IW-1:0]     ld_data,
    input  logic              ld_last,
    output logic              ld_ready,
    input  logic              halt_req,
    input  logic              resume,
    input  logic              step,
    input  logic              reload,
    output logic [1:0]        stage,
    output logic              cpu_en,
    output logic [ADDR_W-1:0] ld_addr,
    output logic [IW-1:0]     ld_word,
    output logic              pc_clr,
    output logic              halted,
    output logic [ADDR_W:0]   loaded_words,
    output logic [CNT_W-1:0]  instr_cnt
);
    typedef enum logic [2:0] {LOAD, FETCH, DECODE, EXECUTE, HALT} state_t;

    state_t state;
    logic   fin_pend;
    logic   step_mode;
    logic   accept;
    logic   final_word;

    assign accept     = ld_valid && ld_ready;
    // the accept that fills the last address is final even without ld_last
    assign final_word = ld_last || (&loaded_words[ADDR_W-1:0]);
    assign stage      = state == HALT ? 2'b01 : state[1:0];
    assign cpu_en     = state != HALT;
    assign halted     = state == HALT;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= LOAD;
            ld_ready     <= 1'b0;
            ld_addr      <= '0;
            ld_word      <= '0;
            loaded_words <= '0;
            instr_cnt    <= '0;
            pc_clr       <= 1'b0;
            fin_pend     <= 1'b0;
            step_mode    <= 1'b0;
        end else begin
            pc_clr <= 1'b0;
            case (state)
                LOAD: begin
                    if (fin_pend) begin
                        state    <= FETCH;
                        pc_clr   <= 1'b1;
                        fin_pend <= 1'b0;
                    end else if (accept) begin
                        ld_addr      <= loaded_words[ADDR_W-1:0];
                        ld_word      <= ld_data;
                        loaded_words <= loaded_words + (ADDR_W+1)'(1);
                        fin_pend     <= final_word;
                        ld_ready     <= !final_word;
                    end else begin
                        ld_ready <= 1'b1;
                    end
                end
                FETCH:   state <= DECODE;
                DECODE:  state <= EXECUTE;
                EXECUTE: begin
                    if (!(&instr_cnt)) instr_cnt <= instr_cnt + CNT_W'(1);
                    state     <= (halt_req || step_mode) ? HALT : FETCH;
                    step_mode <= 1'b0;
                end
                HALT: begin
                    if (reload) begin
                        state        <= LOAD;
                        loaded_words <= '0;
                        ld_addr      <= '0;
                        ld_ready     <= 1'b1;
                    end else if (step) begin
                        state     <= FETCH;
                        step_mode <= 1'b1;
                    end else if (resume) begin
                        state <= FETCH;
                    end
                end
                default: state <= LOAD;
            endcase
        end
    end
endmodule
